// File: rtl/sar_if.sv
// sar_if: bundles the converter control, comparator and DAC switch signals of
// the SAR controller.
//   slave  modport : used by sar_logic (inputs en_i/soc_i/cmp_i, drives the rest)
//   master modport : used by whatever drives the controller (a sequencer or a bench)
// Signals:
//   en_i     converter enable, low aborts to idle
//   soc_i    start-of-conversion request
//   cmp_i    comparator decision, 1 = input >= DAC trial level
//   smpl_o   sample-switch control
//   cmp_en_o comparator strobe, one pulse per bit
//   swp_o    DAC P-side switch word, index 0 = MSB
//   swn_o    DAC N-side switch word, always ~swp_o
//   final_o  conversion complete
//   busy_o   controller not idle
//   ovr_o    sticky overrun: start request seen while busy
interface sar_if #(
   parameter int NBIT = 10
);
   logic            en_i;
   logic            soc_i;
   logic            cmp_i;
   logic            smpl_o;
   logic            cmp_en_o;
   logic [0:NBIT-1] swp_o;
   logic [0:NBIT-1] swn_o;
   logic            final_o;
   logic            busy_o;
   logic            ovr_o;

   modport slave (
      input  en_i, soc_i, cmp_i,
      output smpl_o, cmp_en_o, swp_o, swn_o, final_o, busy_o, ovr_o
   );

   modport master (
      output en_i, soc_i, cmp_i,
      input  smpl_o, cmp_en_o, swp_o, swn_o, final_o, busy_o, ovr_o
   );
endinterface

// File: rtl/sar_logic.sv
// sar_logic: synchronous successive-approximation controller for the SAR ADC.
// A start request samples the input for SAMPLE_CYCLES, then resolves one bit per
// SETTLE_CYCLES+2 step, MSB first, from the comparator decision, freezes the
// code for one cycle and raises final_o for FINAL_CYCLES cycles.
// Ports:
//   clk_i  system clock, all state on the rising edge
//   rst_i  synchronous reset, active high, highest priority
//   bus    sar_if slave modport (control, comparator and DAC switch words)
// Every output is a flop; nothing combinational reaches the outputs.
module sar_logic #(
   parameter int NBIT          = 10,
   parameter int SAMPLE_CYCLES = 2,
   parameter int SETTLE_CYCLES = 1,
   parameter int FINAL_CYCLES  = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   sar_if.slave bus
);

   localparam int STEP_CYCLES = SETTLE_CYCLES + 2;
   localparam int CMAX_A      = (SAMPLE_CYCLES > STEP_CYCLES) ? SAMPLE_CYCLES : STEP_CYCLES;
   localparam int CMAX        = (CMAX_A > FINAL_CYCLES) ? CMAX_A : FINAL_CYCLES;
   localparam int CW          = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int BW          = (NBIT > 1) ? $clog2(NBIT) : 1;

   localparam logic [CW-1:0] SMP_LAST  = CW'(SAMPLE_CYCLES - 1);
   localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
   localparam logic [CW-1:0] STROBE    = CW'(SETTLE_CYCLES);
   localparam logic [CW-1:0] FIN_LAST  = CW'(FINAL_CYCLES - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(NBIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      SAMPLE,
      CONVERT,
      HOLD,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;      // cycles spent in the current phase / bit step
   logic [BW-1:0]   bit_q, bit_d;      // bit under trial, 0 = MSB
   logic [0:NBIT-1] swp_q, swp_d;
   logic [0:NBIT-1] swn_q;
   logic            ovr_q, ovr_d;
   logic            smpl_q, cmp_en_q, final_q, busy_q;
   logic            cmp_en_d;
   logic [BW-1:0]   bit_nxt;

   assign bit_nxt = bit_q + BW'(1);

   // NOTE: every variable gets its default before the case so that no path
   // leaves one unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      swp_d   = swp_q;
      ovr_d   = ovr_q;

      if (!bus.en_i) begin
         // Abort: drop to idle with a cleared DAC word; overrun history is kept.
         state_d = IDLE;
         cnt_d   = '0;
         bit_d   = '0;
         swp_d   = '0;
      end else begin
         // A request while busy is never accepted, only flagged.
         if (state_q != IDLE && bus.soc_i) ovr_d = 1'b1;

         case (state_q)
            IDLE: begin
               if (bus.soc_i) begin
                  state_d = SAMPLE;
                  cnt_d   = '0;
                  swp_d   = '0;
                  ovr_d   = 1'b0;
               end
            end
            SAMPLE: begin
               if (cnt_q == SMP_LAST) begin
                  state_d  = CONVERT;
                  cnt_d    = '0;
                  bit_d    = '0;
                  swp_d[0] = 1'b1;       // MSB trial
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            CONVERT: begin
               if (cnt_q == STEP_LAST) begin
                  // Comparator is only looked at in the last cycle of the step.
                  swp_d[bit_q] = bus.cmp_i;
                  cnt_d        = '0;
                  if (bit_q == BIT_LAST) begin
                     state_d = HOLD;
                  end else begin
                     bit_d          = bit_nxt;
                     swp_d[bit_nxt] = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            HOLD: begin
               // One cycle with the code frozen before final_o rises.
               state_d = DONE;
               cnt_d   = '0;
            end
            DONE: begin
               if (cnt_q == FIN_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               bit_d   = '0;
            end
         endcase
      end

      // Strobe is registered from the next step count so it is high exactly
      // during cycle SETTLE_CYCLES of each bit step.
      cmp_en_d = (state_d == CONVERT) && (cnt_d == STROBE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update
   // from the same pre-edge values.
   always_ff @(posedge clk_i) begin
      // NOTE: synchronous reset covers every flop here; there is no memory
      // array that would be left unreset.
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         swp_q    <= '0;
         swn_q    <= '1;
         ovr_q    <= 1'b0;
         smpl_q   <= 1'b0;
         cmp_en_q <= 1'b0;
         final_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         swp_q    <= swp_d;
         swn_q    <= ~swp_d;
         ovr_q    <= ovr_d;
         smpl_q   <= (state_d == SAMPLE);
         cmp_en_q <= cmp_en_d;
         final_q  <= (state_d == DONE);
         busy_q   <= (state_d != IDLE);
      end
   end

   assign bus.smpl_o   = smpl_q;
   assign bus.cmp_en_o = cmp_en_q;
   assign bus.swp_o    = swp_q;
   assign bus.swn_o    = swn_q;
   assign bus.final_o  = final_q;
   assign bus.busy_o   = busy_q;
   assign bus.ovr_o    = ovr_q;

endmodule

// File: tb/tb_sar_logic.sv
// tb_sar_logic: directed bench for sar_logic with an ideal comparator
// (cmp = vin >= current DAC trial code). A table of input levels and their
// hand-computed codes drives full conversions; hand-written sequences cover
// reset, enable abort, overrun and mid-conversion reset.
module tb_sar_logic;

   localparam int NBIT = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NBIT-1:0] vin = '0;
   logic [NBIT-1:0] code;

   int n_checks = 0;
   int n_fail   = 0;

   sar_if #(.NBIT(NBIT)) bus ();

   sar_logic #(
      .NBIT(NBIT), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(1), .FINAL_CYCLES(2)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   // swp index 0 is the MSB, so the packed copy reads directly as the code.
   assign code       = bus.swp_o;
   assign bus.cmp_i  = (vin >= code);

   typedef struct {
      logic [NBIT-1:0] vin;
      logic [NBIT-1:0] exp_swp;
      logic [NBIT-1:0] exp_swn;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full conversion. soc_at > 0 injects a start request sampled at edge
   // E0+soc_at during the conversion.
   task automatic convert(input logic [NBIT-1:0] v, input logic [NBIT-1:0] exp_swp,
                          input logic [NBIT-1:0] exp_swn, input int soc_at, input string tag);
      int pulses = 0, bad = 0, rise = -1, fall = -1;
      logic prev_final = 1'b0;
      logic [NBIT-1:0] swp32 = '0, swp33 = '0, swn33 = '0;
      vin         = v;
      bus.en_i    = 1'b1;
      bus.soc_i   = 1'b1;
      tick();                               // E0
      bus.soc_i   = 1'b0;
      check({tag, " busy@E0"}, bus.busy_o, 1);
      check({tag, " smpl@E0"}, bus.smpl_o, 1);
      check({tag, " swp@E0"},  code, 0);
      check({tag, " ovr@E0"},  bus.ovr_o, 0);
      for (int n = 1; n <= 36; n++) begin
         bus.soc_i = (n == soc_at);
         tick();
         if (bus.cmp_en_o) begin
            pulses++;
            if (n % 3 != 0) bad++;
         end
         if (bus.final_o && !prev_final) rise = n;
         if (!bus.final_o && prev_final) fall = n;
         prev_final = bus.final_o;
         if (n == 2)  check({tag, " smpl@2"}, bus.smpl_o, 0);
         if (n == 32) swp32 = code;
         if (n == 33) begin
            swp33 = code;
            swn33 = bus.swn_o;
         end
         if (soc_at > 0 && n == soc_at - 1) check({tag, " ovr before"}, bus.ovr_o, 0);
         if (soc_at > 0 && n == soc_at)     check({tag, " ovr after"},  bus.ovr_o, 1);
      end
      bus.soc_i = 1'b0;
      check({tag, " cmp_en pulses"},    pulses, 10);
      check({tag, " cmp_en off-grid"},  bad, 0);
      check({tag, " final rise"},       rise, 33);
      check({tag, " final fall"},       fall, 35);
      check({tag, " swp@32"},           swp32, exp_swp);
      check({tag, " swp@rise"},         swp33, exp_swp);
      check({tag, " swn@rise"},         swn33, exp_swn);
      check({tag, " busy end"},         bus.busy_o, 0);
      check({tag, " swp held"},         code, exp_swp);
   endtask

   initial begin
      int act;
      vecs[0] = '{10'd716,  10'd716,  10'd307};
      vecs[1] = '{10'd0,    10'd0,    10'd1023};
      vecs[2] = '{10'd1023, 10'd1023, 10'd0};
      vecs[3] = '{10'd512,  10'd512,  10'd511};
      vecs[4] = '{10'd341,  10'd341,  10'd682};
      vecs[5] = '{10'd1,    10'd1,    10'd1022};

      bus.en_i  = 1'b1;
      bus.soc_i = 1'b1;

      // Reset held two cycles with a pending start request.
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst busy",   bus.busy_o, 0);
         check("rst smpl",   bus.smpl_o, 0);
         check("rst cmp_en", bus.cmp_en_o, 0);
         check("rst swp",    code, 0);
         check("rst swn",    bus.swn_o, 10'h3ff);
         check("rst final",  bus.final_o, 0);
         check("rst ovr",    bus.ovr_o, 0);
      end
      rst       = 1'b0;
      bus.soc_i = 1'b0;
      tick();
      check("idle busy", bus.busy_o, 0);

      // Table of full conversions.
      for (int i = 0; i < 6; i++)
         convert(vecs[i].vin, vecs[i].exp_swp, vecs[i].exp_swn, 0, $sformatf("vec%0d", i));

      // Overrun request mid-conversion; result unaffected.
      convert(10'd716, 10'd716, 10'd307, 11, "ovr");
      check("ovr sticky", bus.ovr_o, 1);

      // Enable abort after 15 edges, with an overrun flagged beforehand.
      vin       = 10'd716;
      bus.soc_i = 1'b1;
      tick();
      for (int n = 1; n <= 15; n++) begin
         bus.soc_i = (n == 5);
         tick();
      end
      bus.soc_i = 1'b0;
      check("abort ovr set", bus.ovr_o, 1);
      bus.en_i = 1'b0;
      tick();                               // E0+16
      check("abort swp",   code, 0);
      check("abort swn",   bus.swn_o, 10'h3ff);
      check("abort busy",  bus.busy_o, 0);
      check("abort final", bus.final_o, 0);
      check("abort smpl",  bus.smpl_o, 0);
      check("abort ovr kept", bus.ovr_o, 1);
      bus.soc_i = 1'b1;                     // ignored while disabled
      tick();
      tick();
      check("soc en=0 busy", bus.busy_o, 0);
      bus.soc_i = 1'b0;
      bus.en_i  = 1'b1;
      act = 0;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (bus.cmp_en_o || bus.final_o || bus.busy_o) act++;
      end
      check("abort quiet", act, 0);
      convert(10'd716, 10'd716, 10'd307, 0, "post-abort");

      // Reset at E0+20, new start sampled at E0+22.
      vin       = 10'd716;
      bus.soc_i = 1'b1;
      tick();
      bus.soc_i = 1'b0;
      for (int n = 1; n <= 19; n++) tick();
      rst = 1'b1;
      tick();                               // E0+20
      rst = 1'b0;
      check("mid rst busy", bus.busy_o, 0);
      check("mid rst swp",  code, 0);
      check("mid rst swn",  bus.swn_o, 10'h3ff);
      check("mid rst cmp_en", bus.cmp_en_o, 0);
      tick();                               // E0+21
      convert(10'd300, 10'd300, 10'd723, 0, "post-rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
